// File: rtl/btn_debounce.sv
// Push-button front end: per-channel synchronizer, counter debouncer, press/release
// edge strobes and a long-press strobe, plus a combined any_press strobe.
module btn_debounce #(
  parameter int N_BTN             = 4,
  parameter int SYNC_STAGES       = 2,
  parameter int DEBOUNCE_CYCLES   = 16,
  parameter int LONG_PRESS_CYCLES = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long,
  output logic             any_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_PRESS_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);

  // Strobe outputs are single-cycle pulses with no handshake: the consumer must
  // sample them every cycle; there is no back-pressure and nothing is held.
  logic [N_BTN-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
  logic [N_BTN-1:0][CW-1:0]          cnt_q, cnt_d;
  logic [N_BTN-1:0][HW-1:0]          hcnt_q, hcnt_d;
  logic [N_BTN-1:0]                  s;
  logic [N_BTN-1:0]                  level_d, press_d, release_d, long_d;

  always_comb begin
    s = '0;
    for (int i = 0; i < N_BTN; i++) begin
      s[i] = sync_q[i][SYNC_STAGES-1];
    end
  end

  always_comb begin
    sync_d    = sync_q;
    cnt_d     = cnt_q;
    hcnt_d    = hcnt_q;
    level_d   = btn_level;
    press_d   = '0;
    release_d = '0;
    long_d    = '0;
    for (int i = 0; i < N_BTN; i++) begin
      sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], btn_raw[i]};

      // Any cycle where the input agrees with the level restarts the count.
      if (s[i] == btn_level[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        cnt_d[i]     = '0;
        level_d[i]   = s[i];
        press_d[i]   = s[i];
        release_d[i] = ~s[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end

      // Saturating hold count guarantees one long strobe per press.
      if (!btn_level[i]) begin
        hcnt_d[i] = '0;
      end else if (hcnt_q[i] < HOLD_MAX) begin
        hcnt_d[i] = hcnt_q[i] + HW'(1);
      end
      long_d[i] = btn_level[i] && (hcnt_q[i] == HOLD_LAST);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q      <= '0;
      cnt_q       <= '0;
      hcnt_q      <= '0;
      btn_level   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
      btn_long    <= '0;
      any_press   <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      cnt_q       <= cnt_d;
      hcnt_q      <= hcnt_d;
      btn_level   <= level_d;
      btn_press   <= press_d;
      btn_release <= release_d;
      btn_long    <= long_d;
      any_press   <= |press_d;
    end
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce: strobe events are scheduled into an expected
// queue when stimulus is driven and matched cycle-exactly as the DUT emits them.
module tb_btn_debounce;

  localparam int N  = 4;
  localparam int EW = 32 + 3 * N + 1;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level, btn_press, btn_release, btn_long;
  logic         any_press;

  logic [31:0]   cyc = '0;
  logic [EW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_pass   = 0;
  logic [31:0]   t, r;

  btn_debounce #(
    .N_BTN(N), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(16), .LONG_PRESS_CYCLES(64)
  ) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
    .btn_long(btn_long), .any_press(any_press)
  );

  // clock/reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, expv, cyc);
  endtask

  // driver tasks
  task automatic wait_until(input logic [31:0] c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic idle();
    wait_until(cyc + 32'($urandom_range(3, 8)));
  endtask

  task automatic push_ev(input logic [31:0] c, input logic [N-1:0] p, input logic [N-1:0] rl,
                         input logic [N-1:0] lg, input logic a);
    exp_q.push_back({c, p, rl, lg, a});
  endtask

  // scoreboard: every strobe cycle must match the next scheduled event
  always @(negedge clk) begin
    if ((|btn_press) || (|btn_release) || (|btn_long) || any_press) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $error("FAIL unexpected_strobe: observed %h%h%h%h expected none (cycle %0d)",
               btn_press, btn_release, btn_long, any_press, cyc);
      end else begin
        check("strobe_event", 64'({cyc, btn_press, btn_release, btn_long, any_press}),
              64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    // reset held with all buttons pressed: everything stays at 0
    reset   = 1'b0;
    btn_raw = 4'b1111;
    wait_until(5);
    check("rst_level",   64'(btn_level),   64'(0));
    check("rst_press",   64'(btn_press),   64'(0));
    check("rst_release", 64'(btn_release), 64'(0));
    check("rst_long",    64'(btn_long),    64'(0));
    check("rst_any",     64'(any_press),   64'(0));
    reset = 1'b1;
    r = cyc;
    push_ev(r + 18, 4'b1111, 4'b0000, 4'b0000, 1'b1);
    push_ev(r + 82, 4'b0000, 4'b0000, 4'b1111, 1'b0);
    wait_until(r + 17);
    check("rst_rel_level_e17", 64'(btn_level), 64'(0));
    wait_until(r + 18);
    check("rst_rel_level_e18", 64'(btn_level), 64'(4'b1111));
    wait_until(r + 95);
    btn_raw = 4'b0000;
    t = cyc;
    push_ev(t + 18, 4'b0000, 4'b1111, 4'b0000, 1'b0);
    wait_until(t + 17);
    check("all_rel_level_e17", 64'(btn_level), 64'(4'b1111));
    wait_until(t + 18);
    check("all_rel_level_e18", 64'(btn_level), 64'(0));
    idle();

    // clean press on channel 0 with a long hold
    btn_raw[0] = 1'b1;
    t = cyc;
    push_ev(t + 18, 4'b0001, 4'b0000, 4'b0000, 1'b1);
    push_ev(t + 82, 4'b0000, 4'b0000, 4'b0001, 1'b0);
    wait_until(t + 17);
    check("ch0_level_e17", 64'(btn_level), 64'(0));
    wait_until(t + 18);
    check("ch0_level_e18", 64'(btn_level), 64'(4'b0001));
    wait_until(t + 140);
    check("ch0_level_held", 64'(btn_level), 64'(4'b0001));
    btn_raw[0] = 1'b0;
    t = cyc;
    push_ev(t + 18, 4'b0000, 4'b0001, 4'b0000, 1'b0);
    wait_until(t + 20);
    idle();

    // bounce on channel 1: runs of 10 and 15 high never reach the threshold
    btn_raw[1] = 1'b1;
    t = cyc;
    wait_until(t + 10);
    btn_raw[1] = 1'b0;
    wait_until(t + 13);
    btn_raw[1] = 1'b1;
    wait_until(t + 28);
    btn_raw[1] = 1'b0;
    wait_until(t + 40);
    check("ch1_bounce_level_a", 64'(btn_level), 64'(0));
    wait_until(t + 55);
    check("ch1_bounce_level_b", 64'(btn_level), 64'(0));
    btn_raw[1] = 1'b1;
    t = cyc;
    push_ev(t + 18, 4'b0010, 4'b0000, 4'b0000, 1'b1);
    push_ev(t + 38, 4'b0000, 4'b0010, 4'b0000, 1'b0);
    wait_until(t + 20);
    btn_raw[1] = 1'b0;
    check("ch1_level_after_settle", 64'(btn_level), 64'(4'b0010));
    wait_until(t + 38);
    check("ch1_level_released", 64'(btn_level), 64'(0));
    idle();

    // short press on channel 2: released before the long-press threshold
    btn_raw[2] = 1'b1;
    t = cyc;
    push_ev(t + 18, 4'b0100, 4'b0000, 4'b0000, 1'b1);
    push_ev(t + 76, 4'b0000, 4'b0100, 4'b0000, 1'b0);
    wait_until(t + 58);
    check("ch2_level_high", 64'(btn_level), 64'(4'b0100));
    btn_raw[2] = 1'b0;
    wait_until(t + 75);
    check("ch2_level_e75", 64'(btn_level), 64'(4'b0100));
    wait_until(t + 160);
    check("ch2_no_long_level", 64'(btn_level), 64'(0));
    idle();

    // channels 0 and 3 together
    btn_raw = 4'b1001;
    t = cyc;
    push_ev(t + 18, 4'b1001, 4'b0000, 4'b0000, 1'b1);
    push_ev(t + 82, 4'b0000, 4'b0000, 4'b1001, 1'b0);
    wait_until(t + 19);
    check("conc_any_next", 64'(any_press), 64'(0));
    check("conc_press_next", 64'(btn_press), 64'(0));
    check("conc_level", 64'(btn_level), 64'(4'b1001));
    wait_until(t + 90);
    btn_raw = 4'b0000;
    t = cyc;
    push_ev(t + 18, 4'b0000, 4'b1001, 4'b0000, 1'b0);
    wait_until(t + 20);
    idle();

    // reset while channel 0 is mid-count (count 10), button stays held
    btn_raw[0] = 1'b1;
    t = cyc;
    wait_until(t + 12);
    check("midrst_cnt_before", 64'(dut.cnt_q[0]), 64'(10));
    reset = 1'b0;
    #1;
    check("midrst_cnt", 64'(dut.cnt_q[0]), 64'(0));
    check("midrst_level", 64'(btn_level), 64'(0));
    check("midrst_press", 64'(btn_press), 64'(0));
    wait_until(t + 15);
    reset = 1'b1;
    r = cyc;
    push_ev(r + 18, 4'b0001, 4'b0000, 4'b0000, 1'b1);
    push_ev(r + 82, 4'b0000, 4'b0000, 4'b0001, 1'b0);
    wait_until(r + 17);
    check("midrst_level_e17", 64'(btn_level), 64'(0));
    wait_until(r + 18);
    check("midrst_level_e18", 64'(btn_level), 64'(4'b0001));
    wait_until(r + 100);
    btn_raw[0] = 1'b0;
    t = cyc;
    push_ev(t + 18, 4'b0000, 4'b0001, 4'b0000, 1'b0);
    wait_until(t + 40);

    // final report
    check("exp_q_drained", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
